// File: rtl/wb_user_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for one
// transaction, with a cycle watchdog that aborts hung transfers with an error ack.
module wb_user_arbiter #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        irq_o
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ABORT} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic w_req0, w_req1, w_own_cyc;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;

  // last resets to 1 so that master 0 wins the first tie
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_req0 && w_req1) begin
          w_owner_nxt = ~r_last;
          w_state_nxt = S_BUS;
        end else if (w_req0) begin
          w_owner_nxt = 1'b0;
          w_state_nxt = S_BUS;
        end else if (w_req1) begin
          w_owner_nxt = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // a slave ack in the final watchdog cycle still completes normally
        if (s_ack_i || !w_own_cyc) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_owner;
        w_cnt_nxt   = '0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Everything is gated by state, so async reset clears all outputs at once
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = 2'b00;
    irq_o    = 1'b0;
    if (r_state == S_BUS) begin
      s_cyc_o = r_owner ? m1_cyc_i : m0_cyc_i;
      s_stb_o = r_owner ? m1_stb_i : m0_stb_i;
      s_we_o  = r_owner ? m1_we_i  : m0_we_i;
      s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
      s_adr_o = r_owner ? m1_adr_i : m0_adr_i;
      s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
      grant_o = r_owner ? 2'b10 : 2'b01;
      if (r_owner) begin
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
      end else begin
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
      end
    end else if (r_state == S_ABORT) begin
      irq_o = 1'b1;
      if (r_owner) begin
        m1_ack_o = 1'b1;
        m1_err_o = 1'b1;
        m1_dat_o = ERR_DATA;
      end else begin
        m0_ack_o = 1'b1;
        m0_err_o = 1'b1;
        m0_dat_o = ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_wb_user_arbiter.sv
// Directed bench for wb_user_arbiter: round-robin, single write, watchdog abort,
// ack on the expiry cycle, master abort and asynchronous reset.
module tb_wb_user_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [3:0]  m0_sel = 0;
  logic [31:0] m0_adr = 0, m0_dat = 0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [3:0]  m1_sel = 0;
  logic [31:0] m1_adr = 0, m1_dat = 0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic        s_ack;
  logic [31:0] s_rdat = 0;
  logic [1:0]  grant;
  logic        irq;
  logic        ack_drv = 0;
  logic        auto_ack = 0;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] rr_exp [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  // slave model: forced ack, or a 1-cycle-ack slave answering every strobe
  assign s_ack = ack_drv | (auto_ack & s_stb);

  always #5 clk = ~clk;

  wb_user_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_cyc = on; m0_stb = on; m0_we = we; m0_sel = on ? 4'hF : 4'h0;
    m0_adr = adr; m0_dat = dat;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [31:0] adr);
    m1_cyc = on; m1_stb = on; m1_we = we; m1_sel = on ? 4'hF : 4'h0;
    m1_adr = adr; m1_dat = 32'h0;
  endtask

  initial begin
    // reset state
    tick; tick;
    chk("rst_s_cyc", 32'(s_cyc), 32'd0);
    chk("rst_s_stb", 32'(s_stb), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_s_adr", s_adr, 32'd0);
    #3 rst_n = 1'b1;

    // round-robin from reset with a 1-cycle-ack slave
    tick;
    m0_req(1, 0, 32'h3000_0000, 32'h0);
    m1_req(1, 0, 32'h3000_0100);
    auto_ack = 1;
    #1 chk("rr_grant_c0", 32'(grant), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick;
      #1;
      chk($sformatf("rr_grant_c%0d", i + 1), 32'(grant), 32'(rr_exp[i]));
      chk($sformatf("rr_m0_ack_c%0d", i + 1), 32'(m0_ack), 32'(rr_exp[i] == 2'b01));
      chk($sformatf("rr_m1_ack_c%0d", i + 1), 32'(m1_ack), 32'(rr_exp[i] == 2'b10));
    end
    tick;
    m0_req(0, 0, 0, 0);
    m1_req(0, 0, 0);
    auto_ack = 0;
    #1 chk("rr_end_grant", 32'(grant), 32'd0);

    // single write by m0, slave acks two cycles after strobe
    tick;
    m0_req(1, 1, 32'h3000_0004, 32'h1234_5678);
    #1 chk("wr_req_stb", 32'(s_stb), 32'd0);
    tick;
    #1;
    chk("wr_s_cyc", 32'(s_cyc), 32'd1);
    chk("wr_s_stb", 32'(s_stb), 32'd1);
    chk("wr_s_we", 32'(s_we), 32'd1);
    chk("wr_s_sel", 32'(s_sel), 32'hF);
    chk("wr_s_adr", s_adr, 32'h3000_0004);
    chk("wr_s_dat", s_wdat, 32'h1234_5678);
    chk("wr_grant", 32'(grant), 32'd1);
    chk("wr_m0_ack_early", 32'(m0_ack), 32'd0);
    tick;
    #1 chk("wr_m0_ack_wait", 32'(m0_ack), 32'd0);
    tick;
    ack_drv = 1;
    #1;
    chk("wr_m0_ack", 32'(m0_ack), 32'd1);
    chk("wr_m0_err", 32'(m0_err), 32'd0);
    chk("wr_m1_ack", 32'(m1_ack), 32'd0);
    chk("wr_m1_dat", m1_rdat, 32'd0);
    tick;
    ack_drv = 0;
    m0_req(0, 0, 0, 0);
    #1;
    chk("wr_m0_ack_once", 32'(m0_ack), 32'd0);
    chk("wr_idle_grant", 32'(grant), 32'd0);

    // m1 read, slave never acks: watchdog abort
    tick;
    m1_req(1, 0, 32'h3000_0200);
    #1 chk("to_req_stb", 32'(s_stb), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      tick;
      #1;
      chk($sformatf("to_stb_c%0d", i), 32'(s_stb), 32'd1);
      chk($sformatf("to_grant_c%0d", i), 32'(grant), 32'd2);
      chk($sformatf("to_m1_ack_c%0d", i), 32'(m1_ack), 32'd0);
      chk($sformatf("to_irq_c%0d", i), 32'(irq), 32'd0);
    end
    tick;
    #1;
    chk("to_abort_stb", 32'(s_stb), 32'd0);
    chk("to_abort_cyc", 32'(s_cyc), 32'd0);
    chk("to_abort_ack", 32'(m1_ack), 32'd1);
    chk("to_abort_err", 32'(m1_err), 32'd1);
    chk("to_abort_dat", m1_rdat, 32'hDEAD_BEEF);
    chk("to_abort_irq", 32'(irq), 32'd1);
    chk("to_abort_grant", 32'(grant), 32'd0);
    chk("to_abort_m0_ack", 32'(m0_ack), 32'd0);
    tick;
    m1_req(0, 0, 0);
    #1;
    chk("to_after_irq", 32'(irq), 32'd0);
    chk("to_after_ack", 32'(m1_ack), 32'd0);
    chk("to_after_err", 32'(m1_err), 32'd0);

    // m0 read, slave acks in the 8th (last) bus cycle
    tick;
    m0_req(1, 0, 32'h3000_0300, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      tick;
      #1 chk($sformatf("ex_m0_ack_c%0d", i), 32'(m0_ack), 32'd0);
    end
    tick;
    ack_drv = 1;
    s_rdat = 32'hCAFE_0001;
    #1;
    chk("ex_stb", 32'(s_stb), 32'd1);
    chk("ex_m0_ack", 32'(m0_ack), 32'd1);
    chk("ex_m0_dat", m0_rdat, 32'hCAFE_0001);
    chk("ex_m0_err", 32'(m0_err), 32'd0);
    chk("ex_irq", 32'(irq), 32'd0);
    tick;
    ack_drv = 0;
    s_rdat = 32'h0;
    m0_req(0, 0, 0, 0);
    #1;
    chk("ex_after_irq", 32'(irq), 32'd0);
    chk("ex_after_err", 32'(m0_err), 32'd0);
    chk("ex_after_ack", 32'(m0_ack), 32'd0);
    chk("ex_after_grant", 32'(grant), 32'd0);

    // m0 granted, then drops cyc while m1 waits
    tick;
    m0_req(1, 0, 32'h3000_0400, 32'h0);
    tick;
    m1_req(1, 0, 32'h3000_0500);
    #1;
    chk("ma_grant_m0", 32'(grant), 32'd1);
    chk("ma_s_adr_m0", s_adr, 32'h3000_0400);
    tick;
    m0_req(0, 0, 0, 0);
    #1 chk("ma_m0_ack_drop", 32'(m0_ack), 32'd0);
    tick;
    #1;
    chk("ma_idle_grant", 32'(grant), 32'd0);
    chk("ma_idle_m0_ack", 32'(m0_ack), 32'd0);
    tick;
    #1;
    chk("ma_grant_m1", 32'(grant), 32'd2);
    chk("ma_s_adr_m1", s_adr, 32'h3000_0500);

    // async reset between edges while m1 owns the bus and is being acked
    tick;
    ack_drv = 1;
    #1;
    chk("ar_pre_m1_ack", 32'(m1_ack), 32'd1);
    chk("ar_pre_s_cyc", 32'(s_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_s_cyc", 32'(s_cyc), 32'd0);
    chk("ar_grant", 32'(grant), 32'd0);
    chk("ar_m1_ack", 32'(m1_ack), 32'd0);
    chk("ar_m0_ack", 32'(m0_ack), 32'd0);
    ack_drv = 0;
    m0_req(1, 0, 32'h3000_0600, 32'h0);
    tick;
    #1 chk("ar_hold_grant", 32'(grant), 32'd0);
    #3 rst_n = 1'b1;
    tick;
    #1;
    chk("ar_tie_grant", 32'(grant), 32'd1);
    chk("ar_tie_adr", s_adr, 32'h3000_0600);
    m0_req(0, 0, 0, 0);
    m1_req(0, 0, 0);
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
